compute_arbiter: RTL

- Shares the single matrix-vector compute engine among NUM_UNITS accelerator units (the units driving compute_request/compute_ready/compute_done).
- Queues one-cycle request pulses from the units and grants the engine round-robin. It sequences start/done with the engine and returns a per-unit done pulse.
- Drives the engine-side operand mux select (grant_id) and reports busy, timeout and protocol errors.

---
 rtl/compute_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/compute_arbiter.sv
// Round-robin arbiter sharing one matrix-vector compute engine among NUM_UNITS units.
// Captures request pulses, sequences engine start/done, and flags timeouts and protocol misuse.
module compute_arbiter #(
  parameter  int NUM_UNITS      = 4,
  parameter  int TIMEOUT_CYCLES = 255,
  parameter  int CNT_W          = 8,
  localparam int ID_W           = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_UNITS-1:0] unit_req,
  output logic [NUM_UNITS-1:0] unit_ready,
  output logic [NUM_UNITS-1:0] unit_done,
  output logic                 eng_start,
  input  logic                 eng_done,
  output logic [ID_W-1:0]      grant_id,
  output logic                 grant_valid,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 err_protocol
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t                 state_q, state_d;
  logic [NUM_UNITS-1:0]   pending_q, pending_d;
  logic [NUM_UNITS-1:0]   unit_done_q, unit_done_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                   grant_valid_q, grant_valid_d;
  logic                   eng_start_q, eng_start_d;
  logic                   err_timeout_q, err_timeout_d;
  logic                   err_protocol_q, err_protocol_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [NUM_UNITS-1:0]   accept;
  logic [NUM_UNITS-1:0]   grant_oh;
  logic                   bad_req;
  logic [ID_W-1:0]        sel_id;
  logic                   sel_found;
  int                     idx;

  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      unit_ready[i] = ~pending_q[i] & ~(grant_valid_q && (grant_id_q == ID_W'(i)));
    end
  end

  assign accept   = unit_req & unit_ready;
  assign bad_req  = |(unit_req & ~unit_ready);
  assign grant_oh = NUM_UNITS'(1) << grant_id_q;

  // First pending unit at or after rr_ptr, wrapping modulo NUM_UNITS.
  always_comb begin
    sel_id    = '0;
    sel_found = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_UNITS;
      if (!sel_found && pending_q[idx]) begin
        sel_found = 1'b1;
        sel_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q | accept;
    grant_id_d     = grant_id_q;
    grant_valid_d  = grant_valid_q;
    rr_ptr_d       = rr_ptr_q;
    cnt_d          = cnt_q;
    eng_start_d    = 1'b0;
    unit_done_d    = '0;
    err_timeout_d  = err_timeout_q;
    err_protocol_d = err_protocol_q | bad_req | (eng_done && (state_q != S_WAIT));

    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          state_d       = S_ISSUE;
          grant_id_d    = sel_id;
          grant_valid_d = 1'b1;
          eng_start_d   = 1'b1;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done) begin
          state_d     = S_DONE;
          unit_done_d = grant_oh;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d       = S_DONE;
          unit_done_d   = grant_oh;
          err_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        pending_d     = (pending_q & ~grant_oh) | accept;
        rr_ptr_d      = (grant_id_q == ID_W'(NUM_UNITS - 1)) ? '0 : grant_id_q + ID_W'(1);
        grant_valid_d = 1'b0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pending_q      <= '0;
      unit_done_q    <= '0;
      grant_id_q     <= '0;
      rr_ptr_q       <= '0;
      grant_valid_q  <= 1'b0;
      eng_start_q    <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_protocol_q <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      unit_done_q    <= unit_done_d;
      grant_id_q     <= grant_id_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_valid_q  <= grant_valid_d;
      eng_start_q    <= eng_start_d;
      err_timeout_q  <= err_timeout_d;
      err_protocol_q <= err_protocol_d;
      cnt_q          <= cnt_d;
    end
  end

  assign unit_done    = unit_done_q;
  assign eng_start    = eng_start_q;
  assign grant_id     = grant_id_q;
  assign grant_valid  = grant_valid_q;
  assign err_timeout  = err_timeout_q;
  assign err_protocol = err_protocol_q;
  assign busy         = (state_q != S_IDLE) || (|pending_q);

endmodule
